// File: rtl/key_seq_pkg.sv
// rtl/key_seq_pkg.sv - scan codes, key ids, event width and decoder state encoding
package key_seq_pkg;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [1:0] KEY_FLAP  = 2'd0;
  localparam logic [1:0] KEY_DIVE  = 2'd1;
  localparam logic [1:0] KEY_QUIT  = 2'd2;
  localparam logic [1:0] KEY_PAUSE = 2'd3;

  localparam int EV_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] key;
  } key_hit_t;

  // Extended and normal code spaces are looked up separately so a code only maps in its own space.
  function automatic key_hit_t map_code(input logic [7:0] c, input logic ext);
    key_hit_t r;
    r.hit = 1'b0;
    r.key = KEY_FLAP;
    if (ext) begin
      case (c)
        SC_UP:   begin r.hit = 1'b1; r.key = KEY_FLAP; end
        SC_DOWN: begin r.hit = 1'b1; r.key = KEY_DIVE; end
        default: ;
      endcase
    end else begin
      case (c)
        SC_SPACE, SC_W: begin r.hit = 1'b1; r.key = KEY_FLAP; end
        SC_S:           begin r.hit = 1'b1; r.key = KEY_DIVE; end
        SC_X:           begin r.hit = 1'b1; r.key = KEY_QUIT; end
        SC_P:           begin r.hit = 1'b1; r.key = KEY_PAUSE; end
        default: ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - synchronous event FIFO with full/empty and simultaneous push/pop
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_sequencer.sv
// rtl/ps2_key_sequencer.sv - PS/2 make/break/extended decoder to game-key events; KEYSEQ_TYPEMATIC_FILTER_EN drops repeat makes
module ps2_key_sequencer
  import key_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       ev_valid,
  output logic [2:0] ev_data,
  input  logic       ev_ready,
  output logic [3:0] held,
  output logic       overflow
);

  localparam int            TW      = $clog2(PREFIX_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

  dec_state_t       state;
  dec_state_t       state_nx;
  logic [TW-1:0]    to_cnt;
  logic             timeout;
  logic             is_ext;
  logic             is_brk;
  key_hit_t         hit_norm;
  key_hit_t         hit_ext;
  logic             make_ev;
  logic             brk_ev;
  logic [1:0]       ev_key;
  logic             push;
  logic [EV_W-1:0]  push_data;
  logic             fifo_empty;
  logic             fifo_full;

  assign is_ext   = (code == SC_EXT);
  assign is_brk   = (code == SC_BREAK);
  assign hit_norm = map_code(code, 1'b0);
  assign hit_ext  = map_code(code, 1'b1);
  assign timeout  = (state != ST_IDLE) && (to_cnt == TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // A byte arriving on the timeout cycle is still decoded in the prefix state.
  always_comb begin
    state_nx = state;
    if (code_valid) begin
      case (state)
        ST_IDLE:      if (is_brk) state_nx = ST_BREAK;
                      else if (is_ext) state_nx = ST_EXT;
        ST_EXT:       if (is_brk) state_nx = ST_EXT_BREAK;
                      else if (!is_ext) state_nx = ST_IDLE;
        ST_BREAK:     if (is_ext) state_nx = ST_EXT_BREAK;
                      else if (!is_brk) state_nx = ST_IDLE;
        ST_EXT_BREAK: if (!is_ext && !is_brk) state_nx = ST_IDLE;
        default:      state_nx = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nx = ST_IDLE;
    end
  end

  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_key  = hit_norm.key;
    if (code_valid) begin
      case (state)
        ST_IDLE:      make_ev = hit_norm.hit;
        ST_EXT:       begin make_ev = hit_ext.hit; ev_key = hit_ext.key; end
        ST_BREAK:     brk_ev  = hit_norm.hit;
        ST_EXT_BREAK: begin brk_ev = hit_ext.hit; ev_key = hit_ext.key; end
        default: ;
      endcase
    end
  end

`ifdef KEYSEQ_TYPEMATIC_FILTER_EN
  assign push = brk_ev || (make_ev && !held[ev_key]);
`else
  assign push = brk_ev || make_ev;
`endif
  assign push_data = {make_ev, ev_key};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held     <= '0;
      overflow <= 1'b0;
      to_cnt   <= '0;
    end else begin
      if (make_ev)     held[ev_key] <= 1'b1;
      else if (brk_ev) held[ev_key] <= 1'b0;
      if (push && fifo_full && !ev_ready) overflow <= 1'b1;
      if (state == ST_IDLE || code_valid || timeout) to_cnt <= '0;
      else                                           to_cnt <= to_cnt + TW'(1);
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (ev_ready),
    .head      (ev_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb/tb_ps2_key_sequencer.sv - scoreboard bench for ps2_key_sequencer
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 8;
`ifdef KEYSEQ_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_data;
  logic [3:0] held;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb [$];
  logic [7:0] fill_codes [5] = '{8'h29, 8'h1B, 8'h22, 8'h4D, 8'h1D};

  always #5 CLK = ~CLK;

  ps2_key_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .code_valid (code_valid),
    .code       (code),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_ready   (ev_ready),
    .held       (held),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each accepted pop is seen once, at the negedge before the popping posedge.
  always @(negedge CLK) begin
    if (!RST && ev_valid && ev_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("ev_data", 32'(ev_data), 32'(sb.pop_front()));
    end
  end

  task automatic expect_ev(input logic [2:0] e);
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    code = b;
    code_valid = 1'b1;
    @(posedge CLK);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || ev_valid) && n < 64) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    check({tag, "_valid"}, 32'(ev_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_data", 32'(ev_data), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    RST = 1'b0;
    ev_ready = 1'b1;

    // basic make / break
    expect_ev(3'b100);
    send(8'h29);
    check("make_valid", 32'(ev_valid), 32'd1);
    check("make_head", 32'(ev_data), 32'h4);
    check("make_held", 32'(held), 32'h1);
    send(8'hF0);
    expect_ev(3'b000);
    send(8'h29);
    check("break_held", 32'(held), 32'h0);

    // extended make / break
    send(8'hE0);
    expect_ev(3'b101);
    send(8'h72);
    check("ext_make_held", 32'(held), 32'h2);
    send(8'hE0);
    send(8'hF0);
    expect_ev(3'b001);
    send(8'h72);
    check("ext_break_held", 32'(held), 32'h0);
    wait_drain("drain_ext");

    // overflow: fifth make is dropped (or filtered as a repeat)
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_ev({1'b1, 2'(i)});
      send(fill_codes[i]);
    end
    check("ovf_held", 32'(held), 32'hF);
    check("ovf_flag", 32'(overflow), FILT ? 32'd0 : 32'd1);
    ev_ready = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", 32'(overflow), FILT ? 32'd0 : 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(8'hF0);
      expect_ev({1'b0, 2'(i)});
      send(fill_codes[i]);
    end
    check("release_all_held", 32'(held), 32'h0);

    // prefix timeout: abandoned E0 lets 1D decode as normal FLAP
    send(8'hE0);
    repeat (TO) @(posedge CLK);
    #1;
    expect_ev(3'b100);
    send(8'h1D);
    check("timeout_held", 32'(held), 32'h1);
    send(8'hF0);
    expect_ev(3'b000);
    send(8'h1D);
    // just inside the timeout the prefix is still live
    send(8'hE0);
    repeat (TO - 2) @(posedge CLK);
    #1;
    expect_ev(3'b100);
    send(8'h75);
    check("pre_timeout_held", 32'(held), 32'h1);
    send(8'hE0);
    send(8'hF0);
    expect_ev(3'b000);
    send(8'h75);
    check("ext_up_break_held", 32'(held), 32'h0);
    wait_drain("drain_timeout");

    // typematic repeats
    expect_ev(3'b100);
    send(8'h29);
    if (!FILT) expect_ev(3'b100);
    send(8'h29);
    if (!FILT) expect_ev(3'b100);
    send(8'h29);
    check("typematic_held", 32'(held), 32'h1);
    send(8'hF0);
    expect_ev(3'b000);
    send(8'h29);
    wait_drain("drain_typematic");

    // reset mid-prefix with queued events
    ev_ready = 1'b0;
    expect_ev(3'b101);
    send(8'h1B);
    expect_ev(3'b110);
    send(8'h22);
    send(8'hF0);
    check("pre_rst_valid", 32'(ev_valid), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_valid", 32'(ev_valid), 32'd0);
    check("async_rst_held", 32'(held), 32'h0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ev_ready = 1'b1;
    expect_ev(3'b100);
    send(8'h29);
    check("post_rst_held", 32'(held), 32'h1);
    wait_drain("drain_rst");

    // push while full with simultaneous pop: nothing dropped
    ev_ready = 1'b0;
    send(8'hF0);
    expect_ev(3'b000);
    send(8'h29);
    expect_ev(3'b101);
    send(8'h1B);
    expect_ev(3'b110);
    send(8'h22);
    expect_ev(3'b111);
    send(8'h4D);
    send(8'hF0);
    ev_ready = 1'b1;
    expect_ev(3'b001);
    send(8'h1B);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    wait_drain("drain_full");
    check("final_held", 32'(held), 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
